remove_stuff: RTL and testbench

REMOVE_STUFF -- requirements
Module: remove_stuff

---
 rtl/remove_stuff.sv | 155 +++++++++++++++
 tb/tb_remove_stuff.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/remove_stuff.sv
// JPEG entropy-stream unstuffer: strips FF00 stuffing, packs data bytes into
// 32-bit words and queues them with markers in a FWFT FIFO. Optional stats: REMOVE_STUFF_STAT_EN.
module remove_stuff #(
  parameter int FIFO_AW = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_bytes,
  output logic        out_marker,
  output logic [15:0] stuff_cnt,
  output logic [15:0] marker_cnt
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int EW    = 36;
  localparam logic [FIFO_AW:0] CNT_READY_MAX = (FIFO_AW+1)'(DEPTH - 2);

  typedef enum logic {NORM, GOT_FF} state_t;

  state_t               r_state;
  logic [1:0]           r_pk_cnt;
  logic [31:0]          r_pk_data;
  logic [FIFO_AW-1:0]   r_wr_ptr;
  logic [FIFO_AW-1:0]   r_rd_ptr;
  logic [FIFO_AW:0]     r_cnt;
  logic [EW-1:0]        r_mem [DEPTH];

  state_t               w_state_next;
  logic                 w_acc;
  logic                 w_deq;
  logic                 w_append;
  logic                 w_marker;
  logic                 w_flush;
  logic                 w_word_done;
  logic [7:0]           w_app_byte;
  logic [31:0]          w_pk_merged;
  logic [1:0]           w_n_enq;
  logic [EW-1:0]        w_e0;
  logic [EW-1:0]        w_e1;
  logic [EW-1:0]        w_head;
  logic [FIFO_AW-1:0]   w_wr_ptr1;

  assign in_ready  = rst && (r_cnt <= CNT_READY_MAX);
  assign w_acc     = in_valid && in_ready;
  assign out_valid = (r_cnt != '0);
  assign w_deq     = out_valid && out_ready;
  assign w_wr_ptr1 = r_wr_ptr + 1'b1;

  always_comb begin
    w_state_next = r_state;
    w_append     = 1'b0;
    w_marker     = 1'b0;
    w_app_byte   = in_data;
    if (w_acc) begin
      case (r_state)
        NORM: begin
          if (in_data == 8'hFF) w_state_next = GOT_FF;
          else                  w_append     = 1'b1;
        end
        GOT_FF: begin
          if (in_data == 8'h00) begin
            w_append     = 1'b1;
            w_app_byte   = 8'hFF;
            w_state_next = NORM;
          end else if (in_data != 8'hFF) begin
            w_marker     = 1'b1;
            w_state_next = NORM;
          end
        end
        default: w_state_next = NORM;
      endcase
    end

    // ~cnt == 3-cnt: byte lane counted from the MSB end
    w_pk_merged = r_pk_data;
    w_pk_merged[{~r_pk_cnt, 3'b000} +: 8] = w_app_byte;

    w_word_done = w_append && (r_pk_cnt == 2'd3);
    w_flush     = w_marker && (r_pk_cnt != 2'd0);

    w_e1 = {24'h0, in_data, 3'd0, 1'b1};
    if (w_flush)       w_e0 = {r_pk_data, 1'b0, r_pk_cnt, 1'b0};
    else if (w_marker) w_e0 = w_e1;
    else               w_e0 = {w_pk_merged, 3'd4, 1'b0};

    if (w_marker)         w_n_enq = w_flush ? 2'd2 : 2'd1;
    else if (w_word_done) w_n_enq = 2'd1;
    else                  w_n_enq = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= NORM;
      r_pk_cnt  <= 2'd0;
      r_pk_data <= 32'h0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_word_done || w_marker) begin
        r_pk_cnt  <= 2'd0;
        r_pk_data <= 32'h0;
      end else if (w_append) begin
        r_pk_cnt  <= r_pk_cnt + 2'd1;
        r_pk_data <= w_pk_merged;
      end
      r_wr_ptr <= r_wr_ptr + {{(FIFO_AW-2){1'b0}}, w_n_enq};
      r_rd_ptr <= r_rd_ptr + {{(FIFO_AW-1){1'b0}}, w_deq};
      r_cnt    <= r_cnt + {{(FIFO_AW-1){1'b0}}, w_n_enq} - {{FIFO_AW{1'b0}}, w_deq};
    end
  end

  // Storage needs no reset: the count register alone decides what is visible
  always_ff @(posedge clk) begin
    if (w_n_enq != 2'd0) r_mem[r_wr_ptr]  <= w_e0;
    if (w_n_enq == 2'd2) r_mem[w_wr_ptr1] <= w_e1;
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign out_data   = out_valid ? w_head[35:4] : 32'h0;
  assign out_bytes  = out_valid ? w_head[3:1]  : 3'd0;
  assign out_marker = out_valid ? w_head[0]    : 1'b0;

`ifdef REMOVE_STUFF_STAT_EN
  logic        w_stuff;
  logic [15:0] r_stuff_cnt;
  logic [15:0] r_marker_cnt;

  assign w_stuff = w_acc && (r_state == GOT_FF) && (in_data == 8'h00);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stuff_cnt  <= 16'h0;
      r_marker_cnt <= 16'h0;
    end else begin
      if (w_stuff && (r_stuff_cnt != 16'hFFFF))   r_stuff_cnt  <= r_stuff_cnt + 16'd1;
      if (w_marker && (r_marker_cnt != 16'hFFFF)) r_marker_cnt <= r_marker_cnt + 16'd1;
    end
  end

  assign stuff_cnt  = r_stuff_cnt;
  assign marker_cnt = r_marker_cnt;
`else
  assign stuff_cnt  = 16'h0;
  assign marker_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_remove_stuff.sv
// Self-checking bench for remove_stuff: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based stream model.
module tb_remove_stuff;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [2:0]  out_bytes;
  logic        out_marker;
  logic [15:0] stuff_cnt;
  logic [15:0] marker_cnt;

  always #5 clk = ~clk;

  remove_stuff #(.FIFO_AW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_bytes  (out_bytes),
    .out_marker (out_marker),
    .stuff_cnt  (stuff_cnt),
    .marker_cnt (marker_cnt)
  );

  typedef struct {
    logic [31:0] data;
    logic [2:0]  bytes;
    logic        marker;
  } ent_t;

  typedef struct {
    int         len;
    logic [7:0] s [10];
    int         n;
    ent_t       e [2];
    int         st;
    int         mk;
  } vec_t;

  ent_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  bit         use_model = 0;

  // stream model: pending-FF flag, list of packed-but-unsent bytes, counts
  bit         m_pend;
  logic [7:0] m_pk[$];
  int         m_stuff;
  int         m_marker;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s = %h", name, act);
    end
  endtask

  task automatic m_push(input logic [31:0] d, input int nb, input bit mk);
    ent_t e;
    e.data = d; e.bytes = 3'(nb); e.marker = mk;
    exp_q.push_back(e);
  endtask

  task automatic m_emit_pk();
    logic [31:0] d;
    d = 32'h0;
    foreach (m_pk[i]) d = d | (32'(m_pk[i]) << (24 - 8*i));
    m_push(d, m_pk.size(), 1'b0);
    m_pk.delete();
  endtask

  task automatic m_add(input logic [7:0] b);
    m_pk.push_back(b);
    if (m_pk.size() == 4) m_emit_pk();
  endtask

  task automatic m_byte(input logic [7:0] b);
    if (!m_pend) begin
      if (b == 8'hFF) m_pend = 1;
      else            m_add(b);
    end else if (b == 8'h00) begin
      m_add(8'hFF); m_pend = 0; m_stuff++;
    end else if (b != 8'hFF) begin
      if (m_pk.size() > 0) m_emit_pk();
      m_push({24'h0, b}, 0, 1'b1);
      m_marker++; m_pend = 0;
    end
  endtask

  task automatic m_clear();
    m_pend = 0; m_pk.delete(); m_stuff = 0; m_marker = 0; exp_q.delete();
  endtask

  // one clock: drive, sample #1 later, then advance to #1 after the rising edge
  task automatic cycle(input logic v, input logic [7:0] d, input logic ordy, output bit acc);
    ent_t e;
    in_valid = v; in_data = d; out_ready = ordy;
    #1;
    acc = v && in_ready;
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_entry actual=%h/%0d/%0d required=none", out_data, out_bytes, out_marker);
      end else begin
        e = exp_q.pop_front();
        chk("entry", {28'h0, out_data, out_bytes, out_marker}, {28'h0, e.data, e.bytes, e.marker});
      end
    end
    if (acc && use_model) m_byte(d);
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ordy);
    bit a;
    int n;
    a = 0; n = 0;
    while (!a && n < 200) begin cycle(1'b1, b, ordy, a); n++; end
    if (!a) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted byte=%h", b);
    end
  endtask

  task automatic drain();
    bit a;
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin cycle(1'b0, 8'h00, 1'b1, a); n++; end
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    chk("drain_out_valid", {63'h0, out_valid}, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    m_clear();
    @(posedge clk); #1;
    chk("rst_in_ready", {63'h0, in_ready}, 64'd0);
    chk("rst_out", {28'h0, out_valid, out_data, out_bytes}, 64'd0);
    chk("rst_marker", {63'h0, out_marker}, 64'd0);
    rst = 1'b1; #1;
    chk("post_rst_in_ready", {63'h0, in_ready}, 64'd1);
  endtask

  task automatic chk_stats(input int st, input int mk);
`ifdef REMOVE_STUFF_STAT_EN
    chk("stuff_cnt", 64'(stuff_cnt), 64'(st));
    chk("marker_cnt", 64'(marker_cnt), 64'(mk));
`else
    chk("stuff_cnt", 64'(stuff_cnt), 64'd0 & 64'(st));
    chk("marker_cnt", 64'(marker_cnt), 64'd0 & 64'(mk));
`endif
  endtask

  function automatic vec_t mkv(input int len, input logic [79:0] s, input int n,
                               input logic [31:0] d0, input logic [2:0] b0, input logic m0,
                               input logic [31:0] d1, input logic [2:0] b1, input logic m1,
                               input int st, input int mk);
    vec_t v;
    v.len = len;
    for (int i = 0; i < 10; i++) v.s[i] = s[79 - 8*i -: 8];
    v.n = n;
    v.e[0].data = d0; v.e[0].bytes = b0; v.e[0].marker = m0;
    v.e[1].data = d1; v.e[1].bytes = b1; v.e[1].marker = m1;
    v.st = st; v.mk = mk;
    return v;
  endfunction

  vec_t vt [6];

  initial begin
    bit a;
    int acc_n;
    logic [7:0] b;

    vt[0] = mkv(4,  80'h12345678_000000000000, 1, 32'h12345678, 3'd4, 1'b0, 32'h0, 3'd0, 1'b0, 0, 0);
    vt[1] = mkv(6,  80'hFF00ABFF00CD_00000000, 1, 32'hFFABFFCD, 3'd4, 1'b0, 32'h0, 3'd0, 1'b0, 2, 0);
    vt[2] = mkv(4,  80'h1122FFD9_000000000000, 2, 32'h11220000, 3'd2, 1'b0, 32'h000000D9, 3'd0, 1'b1, 0, 1);
    vt[3] = mkv(4,  80'hFFFFFFD0_000000000000, 1, 32'h000000D0, 3'd0, 1'b1, 32'h0, 3'd0, 1'b0, 0, 1);
    vt[4] = mkv(10, 80'hFF00FF00FF00FF00FFD8, 2, 32'hFFFFFFFF, 3'd4, 1'b0, 32'h000000D8, 3'd0, 1'b1, 4, 1);
    vt[5] = mkv(8,  80'h0102030405FF00FF_0000, 1, 32'h01020304, 3'd4, 1'b0, 32'h0, 3'd0, 1'b0, 1, 0);

    // directed vector table
    for (int v = 0; v < 6; v++) begin
      do_reset();
      use_model = 0;
      for (int k = 0; k < vt[v].n; k++) exp_q.push_back(vt[v].e[k]);
      for (int k = 0; k < vt[v].len; k++) send_byte(vt[v].s[k], 1'b1);
      drain();
      chk_stats(vt[v].st, vt[v].mk);
    end

    // latency of one full word and hold stability while stalled
    do_reset();
    use_model = 0;
    cycle(1'b1, 8'h12, 1'b0, a);
    cycle(1'b1, 8'h34, 1'b0, a);
    cycle(1'b1, 8'h56, 1'b0, a);
    chk("pre_word_valid", {63'h0, out_valid}, 64'd0);
    cycle(1'b1, 8'h78, 1'b0, a);
    chk("word_latency", {27'h0, out_valid, out_data, out_bytes, out_marker}, {27'h1, 32'h12345678, 3'd4, 1'b0});
    cycle(1'b0, 8'h00, 1'b0, a);
    cycle(1'b0, 8'h00, 1'b0, a);
    chk("stall_stable", {27'h0, out_valid, out_data, out_bytes, out_marker}, {27'h1, 32'h12345678, 3'd4, 1'b0});
    m_push(32'h12345678, 4, 1'b0);
    drain();

    // backpressure: 15 words fill the FIFO down to one free slot
    do_reset();
    use_model = 1;
    acc_n = 0;
    for (int i = 0; i < 70; i++) begin
      cycle(1'b1, 8'(acc_n + 1), 1'b0, a);
      if (a) acc_n++;
    end
    chk("fill_accepted", 64'(acc_n), 64'd60);
    chk("fill_in_ready", {63'h0, in_ready}, 64'd0);
    while (acc_n < 64) begin
      send_byte(8'(acc_n + 1), 1'b1);
      acc_n++;
    end
    drain();

    // reset mid-word discards the partial word and pending FF
    do_reset();
    use_model = 0;
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'hFF, 1'b1);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    chk("midrst_out_valid", {63'h0, out_valid}, 64'd0);
    m_push(32'hABCDEF01, 4, 1'b0);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b1);
    send_byte(8'hEF, 1'b1);
    send_byte(8'h01, 1'b1);
    drain();
    chk_stats(0, 0);

    // randomized traffic against the stream model, with one reset midway
    do_reset();
    use_model = 1;
    for (int i = 0; i < 3000; i++) begin
      int r;
      if (i == 1500) begin
        do_reset();
        use_model = 1;
      end
      r = $urandom_range(0, 9);
      if (r < 3)      b = 8'hFF;
      else if (r < 5) b = 8'h00;
      else            b = 8'($urandom_range(0, 255));
      cycle(($urandom_range(0, 3) != 0), b, (i % 400 < 40) ? 1'b0 : ($urandom_range(0, 9) < 7), a);
    end
    drain();
    chk_stats(m_stuff, m_marker);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
